// File: rtl/rv_pkg.sv
// ============================================================================
// Module      : rv_pkg
// Description : Shared widths, write-back entry type and constants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_pkg;

    localparam int DWIDTH = 32;
    localparam int AWIDTH = 5;

    typedef struct packed {
        logic              valid;
        logic [AWIDTH-1:0] wa;
        logic [DWIDTH-1:0] wd;
    } wb_entry_t;

    localparam logic [AWIDTH-1:0] REG_ZERO = '0;

endpackage

`default_nettype wire

// File: rtl/rf_wb_match.sv
// ============================================================================
// Module      : rf_wb_match
// Description : Youngest-match search of a lookup address over queued entries.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_wb_match
    import rv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTRW  = 2
) (
    input  wb_entry_t [DEPTH-1:0] i_entries,
    input  logic [PTRW-1:0]       i_rd_ptr,
    input  logic [AWIDTH-1:0]     i_ra,
    output logic                  o_hit,
    output logic [DWIDTH-1:0]     o_data
);

    logic [PTRW-1:0] w_idx;

    // Walk oldest to youngest starting at the head; a later match overrides.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = i_rd_ptr + PTRW'(i);
            if (i_entries[w_idx].valid && (i_entries[w_idx].wa == i_ra) &&
                (i_ra != REG_ZERO)) begin
                o_hit  = 1'b1;
                o_data = i_entries[w_idx].wd;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rf_wb_buffer.sv
// ============================================================================
// Module      : rf_wb_buffer
// Description : In-order write-back queue feeding the register-file write
//               port, with two combinational bypass lookup ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_wb_buffer #(
    parameter int DWIDTH = rv_pkg::DWIDTH,
    parameter int AWIDTH = rv_pkg::AWIDTH,
    parameter int DEPTH  = 4,
    parameter int PTRW   = 2
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [AWIDTH-1:0] IN_WA,
    input  logic [DWIDTH-1:0] IN_WD,
    input  logic              DRAIN_EN,
    output logic              RF_WE,
    output logic [AWIDTH-1:0] RF_WA,
    output logic [DWIDTH-1:0] RF_WD,
    input  logic [AWIDTH-1:0] LK_RA1,
    input  logic [AWIDTH-1:0] LK_RA2,
    output logic              LK_HIT1,
    output logic              LK_HIT2,
    output logic [DWIDTH-1:0] LK_D1,
    output logic [DWIDTH-1:0] LK_D2,
    output logic [PTRW:0]     COUNT,
    output logic              EMPTY,
    output logic              FULL
);

    import rv_pkg::*;

    localparam logic [PTRW:0] c_FULL_COUNT = (PTRW+1)'(DEPTH);

    wb_entry_t [DEPTH-1:0] r_entries;
    logic [PTRW-1:0]       r_wr_ptr;
    logic [PTRW-1:0]       r_rd_ptr;
    logic [PTRW:0]         r_count;

    wb_entry_t w_head;
    logic      w_empty;
    logic      w_full;
    logic      w_pop;
    logic      w_push;

    assign w_head  = r_entries[r_rd_ptr];
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL_COUNT);
    assign w_pop   = !w_empty && DRAIN_EN;
    // x0 requests complete the handshake but never occupy an entry.
    assign w_push  = IN_VALID && IN_READY && (IN_WA != REG_ZERO);

    assign RF_WE    = w_pop;
    assign IN_READY = !w_full || w_pop;
    assign RF_WA    = w_empty ? '0 : w_head.wa;
    assign RF_WD    = w_empty ? '0 : w_head.wd;
    assign COUNT    = r_count;
    assign EMPTY    = w_empty;
    assign FULL     = w_full;

    // Push is applied after pop so a full-buffer push into the slot being
    // retired this cycle leaves it valid.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_entries <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
        end else begin
            if (w_pop) begin
                r_entries[r_rd_ptr].valid <= 1'b0;
                r_rd_ptr                  <= r_rd_ptr + 1'b1;
            end
            if (w_push) begin
                r_entries[r_wr_ptr].valid <= 1'b1;
                r_entries[r_wr_ptr].wa    <= IN_WA;
                r_entries[r_wr_ptr].wd    <= IN_WD;
                r_wr_ptr                  <= r_wr_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    rf_wb_match #(
        .DEPTH (DEPTH),
        .PTRW  (PTRW)
    ) u_match1 (
        .i_entries (r_entries),
        .i_rd_ptr  (r_rd_ptr),
        .i_ra      (LK_RA1),
        .o_hit     (LK_HIT1),
        .o_data    (LK_D1)
    );

    rf_wb_match #(
        .DEPTH (DEPTH),
        .PTRW  (PTRW)
    ) u_match2 (
        .i_entries (r_entries),
        .i_rd_ptr  (r_rd_ptr),
        .i_ra      (LK_RA2),
        .o_hit     (LK_HIT2),
        .o_data    (LK_D2)
    );

    a_count_bound: assert property (@(posedge CLK) disable iff (!RSTn)
        r_count <= c_FULL_COUNT);

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_buffer.sv
// ============================================================================
// Module      : tb_rf_wb_buffer
// Description : Scoreboard bench for rf_wb_buffer with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rf_wb_buffer;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [4:0]  IN_WA = '0;
    logic [31:0] IN_WD = '0;
    logic        DRAIN_EN = 1'b0;
    logic        RF_WE;
    logic [4:0]  RF_WA;
    logic [31:0] RF_WD;
    logic [4:0]  LK_RA1 = '0;
    logic [4:0]  LK_RA2 = '0;
    logic        LK_HIT1, LK_HIT2;
    logic [31:0] LK_D1, LK_D2;
    logic [2:0]  COUNT;
    logic        EMPTY, FULL;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  wa;
        logic [31:0] wd;
    } exp_t;
    exp_t sb[$];

    rf_wb_buffer #(
        .DWIDTH (32),
        .AWIDTH (5),
        .DEPTH  (4),
        .PTRW   (2)
    ) dut (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .IN_WA    (IN_WA),
        .IN_WD    (IN_WD),
        .DRAIN_EN (DRAIN_EN),
        .RF_WE    (RF_WE),
        .RF_WA    (RF_WA),
        .RF_WD    (RF_WD),
        .LK_RA1   (LK_RA1),
        .LK_RA2   (LK_RA2),
        .LK_HIT1  (LK_HIT1),
        .LK_HIT2  (LK_HIT2),
        .LK_D1    (LK_D1),
        .LK_D2    (LK_D2),
        .COUNT    (COUNT),
        .EMPTY    (EMPTY),
        .FULL     (FULL)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Register-file side: every write must match the oldest expected entry.
    always @(negedge CLK) begin
        if (RSTn === 1'b1 && RF_WE === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual wa=%0h wd=%0h required no write",
                         RF_WA, RF_WD);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rf_wa", 32'(RF_WA), 32'(e.wa));
                check("rf_wd", RF_WD, e.wd);
            end
        end
    end

    task automatic expect_write(input logic [4:0] wa, input logic [31:0] wd);
        exp_t e;
        e.wa = wa;
        e.wd = wd;
        sb.push_back(e);
    endtask

    task automatic push(input logic [4:0] wa, input logic [31:0] wd);
        @(posedge CLK);
        #1;
        IN_VALID = 1'b1;
        IN_WA    = wa;
        IN_WD    = wd;
        @(negedge CLK);
        check("in_ready", 32'(IN_READY), 32'd1);
        if (wa != 5'd0) expect_write(wa, wd);
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (EMPTY !== 1'b1 && n < 20) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check("drain_to_empty", 32'(EMPTY), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_count", 32'(COUNT), 32'd0);
        check("rst_empty", 32'(EMPTY), 32'd1);
        check("rst_full", 32'(FULL), 32'd0);
        check("rst_in_ready", 32'(IN_READY), 32'd1);
        check("rst_rf_we", 32'(RF_WE), 32'd0);
        check("rst_hit1", 32'(LK_HIT1), 32'd0);
        RSTn = 1'b1;

        // Basic: retire one cycle after acceptance
        DRAIN_EN = 1'b1;
        push(5'd5, 32'hA5);
        @(negedge CLK);
        check("basic_we", 32'(RF_WE), 32'd1);
        check("basic_wa", 32'(RF_WA), 32'd5);
        @(posedge CLK);
        #1;
        check("basic_empty", 32'(EMPTY), 32'd1);
        check("basic_we_after", 32'(RF_WE), 32'd0);

        // Fill and stall, then push into a full buffer while it drains
        DRAIN_EN = 1'b0;
        for (int i = 1; i <= 4; i++) push(5'(i), 32'h100 + 32'(i));
        check("fill_count", 32'(COUNT), 32'd4);
        check("fill_full", 32'(FULL), 32'd1);
        check("fill_in_ready", 32'(IN_READY), 32'd0);
        check("fill_rf_we", 32'(RF_WE), 32'd0);
        LK_RA1 = 5'd3;
        #1;
        check("fill_hit1", 32'(LK_HIT1), 32'd1);
        check("fill_d1", LK_D1, 32'h103);
        DRAIN_EN = 1'b1;
        IN_VALID = 1'b1;
        IN_WA    = 5'd6;
        IN_WD    = 32'h66;
        #1;
        check("full_push_ready", 32'(IN_READY), 32'd1);
        check("full_push_we", 32'(RF_WE), 32'd1);
        expect_write(5'd6, 32'h66);
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        check("full_push_count", 32'(COUNT), 32'd4);
        wait_empty();

        // x0 request: handshake completes, nothing enqueued
        DRAIN_EN = 1'b0;
        push(5'd0, 32'hDEAD);
        check("x0_count", 32'(COUNT), 32'd0);
        check("x0_empty", 32'(EMPTY), 32'd1);
        LK_RA1 = 5'd0;
        #1;
        check("x0_hit1", 32'(LK_HIT1), 32'd0);

        // Bypass: youngest match wins, IN_* invisible until pushed
        push(5'd7, 32'h11);
        push(5'd7, 32'h22);
        LK_RA1 = 5'd7;
        LK_RA2 = 5'd8;
        #1;
        check("byp_hit1", 32'(LK_HIT1), 32'd1);
        check("byp_d1", LK_D1, 32'h22);
        check("byp_hit2", 32'(LK_HIT2), 32'd0);
        check("byp_d2", LK_D2, 32'h0);
        @(posedge CLK);
        #1;
        IN_VALID = 1'b1;
        IN_WA    = 5'd9;
        IN_WD    = 32'h99;
        LK_RA2   = 5'd9;
        #1;
        check("byp_in_invisible", 32'(LK_HIT2), 32'd0);
        expect_write(5'd9, 32'h99);
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        check("byp_pushed_hit2", 32'(LK_HIT2), 32'd1);
        check("byp_pushed_d2", LK_D2, 32'h99);
        DRAIN_EN = 1'b1;
        #1;
        check("byp_drain_we", 32'(RF_WE), 32'd1);
        check("byp_drain_hit1", 32'(LK_HIT1), 32'd1);
        check("byp_drain_d1", LK_D1, 32'h22);
        wait_empty();
        check("byp_after_hit1", 32'(LK_HIT1), 32'd0);
        check("byp_after_d1", LK_D1, 32'h0);

        // Wrap: back-to-back push/pop pairs at COUNT=1
        DRAIN_EN = 1'b0;
        push(5'd10, 32'h1000);
        DRAIN_EN = 1'b1;
        IN_VALID = 1'b1;
        for (int i = 0; i < 10; i++) begin
            IN_WA = 5'(11 + i);
            IN_WD = 32'h2000 + 32'(i);
            @(negedge CLK);
            check("wrap_count", 32'(COUNT), 32'd1);
            check("wrap_ready", 32'(IN_READY), 32'd1);
            expect_write(5'(11 + i), 32'h2000 + 32'(i));
            @(posedge CLK);
            #1;
        end
        IN_VALID = 1'b0;
        wait_empty();

        // Asynchronous reset mid-run discards pending entries
        DRAIN_EN = 1'b0;
        push(5'd12, 32'h12);
        push(5'd13, 32'h13);
        push(5'd14, 32'h14);
        check("pre_rst_count", 32'(COUNT), 32'd3);
        LK_RA1 = 5'd13;
        @(negedge CLK);
        #2;
        RSTn = 1'b0;
        #1;
        check("mid_rst_count", 32'(COUNT), 32'd0);
        check("mid_rst_we", 32'(RF_WE), 32'd0);
        check("mid_rst_hit1", 32'(LK_HIT1), 32'd0);
        check("mid_rst_empty", 32'(EMPTY), 32'd1);
        sb.delete();
        @(negedge CLK);
        RSTn = 1'b1;
        DRAIN_EN = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        check("post_rst_empty", 32'(EMPTY), 32'd0 + 32'd1);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
